// File: rtl/hazard_pkg.sv
// hazard_pkg: types and helpers shared by the hazard scoreboard.
//   slot_t    : one in-flight producer record {valid, rd, load}
//   FWD_RF    : forward-select value meaning "use the ID/EX regfile operand"
//   fwd_w()   : forward-select width for a given load latency
// RD_MAX_W bounds the register address width that fits in a slot. Narrower
// addresses are zero-extended on entry.
package hazard_pkg;

    localparam int RD_MAX_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                load;
    } slot_t;

    // The select must encode 0 (regfile) through DEPTH-1, with DEPTH = lat+2.
    function automatic int fwd_w(input int load_lat);
        return $clog2(load_lat + 2);
    endfunction

endpackage

// File: rtl/hazard_slot_shift.sv
// hazard_slot_shift: DEPTH-entry shift register of in-flight producers.
// slot 0 = EX ... slot DEPTH-1 = WB.
//   clk_i, rst_i : clock, synchronous active-high reset (all slots invalid)
//   hold_i       : freeze every slot
//   bubble_i     : advance, but slot 0 receives an invalid entry
//   slot_in_i    : entry loaded into slot 0 on a normal advance
//   slots_o      : current slot contents
module hazard_slot_shift
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hold_i,
    input  logic                  bubble_i,
    input  slot_t                 slot_in_i,
    output slot_t [DEPTH-1:0]     slots_o
);

    slot_t [DEPTH-1:0] slots_q;
    slot_t [DEPTH-1:0] slots_d;

    always_comb begin
        slots_d = slots_q;
        if (!hold_i) begin
            slots_d[0] = bubble_i ? '0 : slot_in_i;
            for (int i = 1; i < DEPTH; i++) begin
                slots_d[i] = slots_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign slots_o = slots_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard detection and EX forwarding control for
// the in-order pipeline.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   id_valid_i                   : ID holds a real instruction
//   id_rs_i/id_rs_use_i          : ID source A and its read enable
//   id_rt_i/id_rt_use_i          : ID source B and its read enable
//   id_rd_i/id_wen_i/id_load_i   : ID destination, write enable, load flag
//   flush_i                      : kill the ID instruction (branch redirect)
//   mem_busy_i                   : freeze the whole pipeline
//   pc_stall_o/ifid_stall_o      : hold PC / IF-ID (combinational)
//   bubble_o                     : zero ID/EX control (combinational)
//   fwd_rs_o/fwd_rt_o            : EX operand source, 0 = regfile, k = slot k
// Optional macro HAZ_PERF_EN adds perf_stall_o / perf_freeze_o, saturating
// 32-bit counts of load-use stall cycles and mem_busy cycles.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int LOAD_LAT = 1,
    localparam int DEPTH    = LOAD_LAT + 2,
    localparam int FW       = fwd_w(LOAD_LAT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic              id_rs_use_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rt_use_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_wen_i,
    input  logic              id_load_i,
    input  logic              flush_i,
    input  logic              mem_busy_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              bubble_o,
    output logic [FW-1:0]     fwd_rs_o,
    output logic [FW-1:0]     fwd_rt_o
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall_o,
    output logic [31:0]       perf_freeze_o
`endif
);

    slot_t [DEPTH-1:0]   slots;
    slot_t               slot_in;
    logic [RD_MAX_W-1:0] rs_ext, rt_ext;
    logic [FW-1:0]       rs_sel, rt_sel;
    logic                rs_ready, rt_ready;
    logic                load_use;
    logic                kill_id;
    logic [FW-1:0]       fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;

    assign rs_ext = RD_MAX_W'(id_rs_i);
    assign rt_ext = RD_MAX_W'(id_rt_i);

    // Scan oldest to youngest so the youngest match overwrites. The WB slot
    // is excluded: the regfile writes before it is read.
    always_comb begin
        rs_sel   = FW'(FWD_RF);
        rt_sel   = FW'(FWD_RF);
        rs_ready = 1'b1;
        rt_ready = 1'b1;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (id_valid_i && id_rs_use_i && (id_rs_i != '0) &&
                slots[j].valid && (slots[j].rd == rs_ext)) begin
                rs_sel   = FW'(j + 1);
                rs_ready = !slots[j].load || (j >= LOAD_LAT);
            end
            if (id_valid_i && id_rt_use_i && (id_rt_i != '0) &&
                slots[j].valid && (slots[j].rd == rt_ext)) begin
                rt_sel   = FW'(j + 1);
                rt_ready = !slots[j].load || (j >= LOAD_LAT);
            end
        end
    end

    assign load_use = !rs_ready || !rt_ready;
    assign kill_id  = flush_i || load_use;

    always_comb begin
        pc_stall_o   = 1'b0;
        ifid_stall_o = 1'b0;
        bubble_o     = 1'b0;
        if (rst_i) begin
            pc_stall_o = 1'b0;
        end else if (mem_busy_i) begin
            pc_stall_o   = 1'b1;
            ifid_stall_o = 1'b1;
        end else if (flush_i) begin
            // PC must be free to take the redirect even when a hazard exists.
            bubble_o = 1'b1;
        end else if (load_use) begin
            pc_stall_o   = 1'b1;
            ifid_stall_o = 1'b1;
            bubble_o     = 1'b1;
        end
    end

    assign slot_in = '{valid: id_valid_i && id_wen_i && (id_rd_i != '0),
                       rd:    RD_MAX_W'(id_rd_i),
                       load:  id_load_i};

    hazard_slot_shift #(.DEPTH(DEPTH)) u_shift (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (mem_busy_i),
        .bubble_i  (kill_id),
        .slot_in_i (slot_in),
        .slots_o   (slots)
    );

    always_comb begin
        fwd_rs_d = fwd_rs_q;
        fwd_rt_d = fwd_rt_q;
        if (!mem_busy_i) begin
            fwd_rs_d = kill_id ? FW'(FWD_RF) : rs_sel;
            fwd_rt_d = kill_id ? FW'(FWD_RF) : rt_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_rs_q <= '0;
            fwd_rt_q <= '0;
        end else begin
            fwd_rs_q <= fwd_rs_d;
            fwd_rt_q <= fwd_rt_d;
        end
    end

    assign fwd_rs_o = fwd_rs_q;
    assign fwd_rt_o = fwd_rt_q;

`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_q, perf_freeze_q;
    logic        stall_cycle;

    assign stall_cycle = !mem_busy_i && !flush_i && load_use;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q  <= '0;
            perf_freeze_q <= '0;
        end else begin
            if (stall_cycle && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (mem_busy_i && (perf_freeze_q != 32'hFFFF_FFFF)) begin
                perf_freeze_q <= perf_freeze_q + 32'd1;
            end
        end
    end

    assign perf_stall_o  = perf_stall_q;
    assign perf_freeze_o = perf_freeze_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=1 and LOAD_LAT=2)
// share one stimulus stream. Each driven cycle pushes the expected outputs
// of the instance under test; a negedge monitor pops and compares.
// Expected word: {sel, pc_stall, ifid_stall, bubble, fwd_rs[1:0], fwd_rt[1:0]}.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_rs_use, id_rt_use, id_wen, id_load;
  logic       flush, mem_busy;

  logic       pc1, ifid1, bub1, pc2, ifid2, bub2;
  logic [1:0] frs1, frt1, frs2, frt2;

  logic [7:0] exp_q[$];
  int         tag_q[$];
  int         n_cmp;
  int         n_fail;
  int         cyc_no;
  logic       cur_sel;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rs_use_i(id_rs_use),
    .id_rt_i(id_rt), .id_rt_use_i(id_rt_use),
    .id_rd_i(id_rd), .id_wen_i(id_wen), .id_load_i(id_load),
    .flush_i(flush), .mem_busy_i(mem_busy),
    .pc_stall_o(pc1), .ifid_stall_o(ifid1), .bubble_o(bub1),
    .fwd_rs_o(frs1), .fwd_rt_o(frt1)
  );

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rs_use_i(id_rs_use),
    .id_rt_i(id_rt), .id_rt_use_i(id_rt_use),
    .id_rd_i(id_rd), .id_wen_i(id_wen), .id_load_i(id_load),
    .flush_i(flush), .mem_busy_i(mem_busy),
    .pc_stall_o(pc2), .ifid_stall_o(ifid2), .bubble_o(bub2),
    .fwd_rs_o(frs2), .fwd_rt_o(frt2)
  );

  // driver: one ID cycle. Loads read only rs; every valid instruction writes rd.
  task automatic drive(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic v, input logic ld, input logic fl, input logic mb,
                       input logic rs_t, input logic [2:0] stl,
                       input logic [1:0] frs, input logic [1:0] frt);
    id_valid  = v;
    id_rd     = rd;
    id_rs     = rs;
    id_rt     = rt;
    id_rs_use = v;
    id_rt_use = v && !ld;
    id_wen    = v;
    id_load   = ld;
    flush     = fl;
    mem_busy  = mb;
    rst       = rs_t;
    cyc_no++;
    exp_q.push_back({cur_sel, stl, frs, frt});
    tag_q.push_back(cyc_no);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic [1:0] frs, input logic [1:0] frt);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, frs, frt);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] e;
    logic [6:0] act;
    int         t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = e[7] ? {pc2, ifid2, bub2, frs2, frt2} : {pc1, ifid1, bub1, frs1, frt1};
      n_cmp++;
      if (act !== e[6:0]) begin
        n_fail++;
        $display("FAIL cyc%0d lat%0d {pc,ifid,bub,frs,frt}: got %b want %b",
                 t, e[7] ? 2 : 1, act, e[6:0]);
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc_no = 0; cur_sel = 1'b0;
    rst = 1'b1; id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    id_rs_use = 1'b1; id_rt_use = 1'b1; id_wen = 1'b1; id_load = 1'b0;
    flush = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1;

    // ---- LOAD_LAT = 1 instance ----
    // reset with a valid ID instruction present
    drive(5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0);
    drive(5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0);
    // add r3; sub r6,r3,r1 -> EX-slot forward
    drive(5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    drive(5'd6, 5'd3, 5'd1, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    nop(2'd1, 2'd0);
    // lw r5; add r7,r5,r5 -> one stall, then forward from slot 2
    drive(5'd5, 5'd1, 5'd0, 1, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 0, 3'b111, 2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    nop(2'd2, 2'd2);
    // add r4; add r4; use r4 -> youngest producer wins
    drive(5'd4, 5'd1, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    drive(5'd4, 5'd1, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    drive(5'd8, 5'd4, 5'd4, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    // write r0, then read r0 -> never forwarded
    drive(5'd0, 5'd1, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd1, 2'd1);
    drive(5'd9, 5'd0, 5'd0, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    // r8 sits only in the WB slot -> no forward
    drive(5'd10, 5'd8, 5'd1, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    nop(2'd0, 2'd0);
    // mem_busy for three cycles holds fwd and raises the stalls
    drive(5'd11, 5'd1, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    drive(5'd12, 5'd11, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(5'd13, 5'd12, 5'd11, 1, 0, 0, 1, 0, 3'b110, 2'd1, 2'd0);
    end
    drive(5'd13, 5'd12, 5'd11, 1, 0, 0, 0, 0, 3'b000, 2'd1, 2'd0);
    // flush during a load-use hazard -> bubble only
    drive(5'd14, 5'd1, 5'd0, 1, 1, 0, 0, 0, 3'b000, 2'd1, 2'd2);
    drive(5'd15, 5'd14, 5'd0, 1, 0, 1, 0, 0, 3'b001, 2'd0, 2'd0);
    nop(2'd0, 2'd0);

    // ---- LOAD_LAT = 2 instance ----
    cur_sel = 1'b1;
    drive(5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0);
    drive(5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0);
    // lw r5; back-to-back use -> two stalls, forward from slot 3
    drive(5'd5, 5'd1, 5'd0, 1, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 0, 3'b111, 2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 0, 3'b111, 2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    nop(2'd3, 2'd3);
    // lw r5; one gap; use -> one stall, forward from slot 3
    drive(5'd5, 5'd1, 5'd0, 1, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    nop(2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd2, 1, 0, 0, 0, 0, 3'b111, 2'd0, 2'd0);
    drive(5'd7, 5'd5, 5'd2, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0);
    nop(2'd3, 2'd0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
